// File: rtl/addition_pkg.sv
// Shared types and saturation limits for the signed saturating adder.
package addition_pkg;

  typedef enum logic [1:0] {
    OVF_NONE = 2'd0,
    OVF_POS  = 2'd1,
    OVF_NEG  = 2'd2
  } ovf_t;

  // Limits are returned at 64 bits; callers slice to their own width.
  function automatic logic signed [63:0] sat_max(input int width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int width);
    return -(64'sd1 <<< (width - 1));
  endfunction

endpackage

// File: rtl/addition_sat_add_comb.sv
// Purely combinational two's-complement saturating adder with overflow status.
module sat_add_comb
  import addition_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s,
  output ovf_t             ovf
);

  localparam logic signed [63:0]    MAX_64  = sat_max(WIDTH);
  localparam logic signed [63:0]    MIN_64  = sat_min(WIDTH);
  localparam logic signed [WIDTH:0] MAX_EXT = MAX_64[WIDTH:0];
  localparam logic signed [WIDTH:0] MIN_EXT = MIN_64[WIDTH:0];

  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic signed [WIDTH:0]   sum_full;

  assign a_s      = $signed(a);
  assign b_s      = $signed(b);
  assign sum_full = $signed({a_s[WIDTH-1], a_s}) + $signed({b_s[WIDTH-1], b_s});

  // Only same-sign operands can leave the WIDTH-bit range.
  always_comb begin
    s   = sum_full[WIDTH-1:0];
    ovf = OVF_NONE;
    if (!a_s[WIDTH-1] && !b_s[WIDTH-1] && (sum_full > MAX_EXT)) begin
      s   = MAX_EXT[WIDTH-1:0];
      ovf = OVF_POS;
    end else if (a_s[WIDTH-1] && b_s[WIDTH-1] && (sum_full < MIN_EXT)) begin
      s   = MIN_EXT[WIDTH-1:0];
      ovf = OVF_NEG;
    end
  end

endmodule

// File: rtl/addition.sv
// Saturating adder: combinational sum plus a registered copy with overflow flags.
// Optional saturation event counter enabled by defining ADDITION_SAT_COUNT_EN.
module addition
  import addition_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic [WIDTH-1:0]     S,
  input  logic                 in_valid,
  output logic [WIDTH-1:0]     S_q,
  output logic                 out_valid,
  output logic                 ovf_pos,
  output logic                 ovf_neg,
  output logic                 sticky_ovf,
  input  logic                 clr_sticky
`ifdef ADDITION_SAT_COUNT_EN
  ,
  output logic [CNT_WIDTH-1:0] sat_count
`endif
);

  ovf_t       ovf_p0;
  logic       sat_evt_p0;

  logic [WIDTH-1:0] s_p1;
  logic             vld_p1;
  logic             ovf_pos_p1;
  logic             ovf_neg_p1;
  logic             sticky_p1;

  sat_add_comb #(
    .WIDTH (WIDTH)
  ) u_sat_add (
    .a   (A),
    .b   (B),
    .s   (S),
    .ovf (ovf_p0)
  );

  assign sat_evt_p0 = in_valid && (ovf_p0 != OVF_NONE);

  // ---- stage p0 -> p1: capture accepted sample ----
  always_ff @(posedge clk) begin
    if (rst) begin
      s_p1       <= '0;
      vld_p1     <= 1'b0;
      ovf_pos_p1 <= 1'b0;
      ovf_neg_p1 <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        s_p1       <= S;
        ovf_pos_p1 <= (ovf_p0 == OVF_POS);
        ovf_neg_p1 <= (ovf_p0 == OVF_NEG);
      end
    end
  end

  // A saturation event in the same cycle as a clear wins, so no event is lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_p1 <= 1'b0;
    end else if (sat_evt_p0) begin
      sticky_p1 <= 1'b1;
    end else if (clr_sticky) begin
      sticky_p1 <= 1'b0;
    end
  end

`ifdef ADDITION_SAT_COUNT_EN
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] cnt_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_p1 <= '0;
    end else if (sat_evt_p0) begin
      if (clr_sticky) begin
        cnt_p1 <= CNT_ONE;
      end else if (cnt_p1 != CNT_MAX) begin
        cnt_p1 <= cnt_p1 + CNT_ONE;
      end
    end else if (clr_sticky) begin
      cnt_p1 <= '0;
    end
  end

  assign sat_count = cnt_p1;
`else
  localparam int unused_cnt_width = CNT_WIDTH;
`endif

  assign S_q        = s_p1;
  assign out_valid  = vld_p1;
  assign ovf_pos    = ovf_pos_p1;
  assign ovf_neg    = ovf_neg_p1;
  assign sticky_ovf = sticky_p1;

endmodule

// File: tb/tb_addition.sv
// Testbench for addition: vector table, directed corner sequences, randomized run vs reference model.
module tb_addition;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         clr_sticky;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] S;
  logic [W-1:0] S_q;
  logic         out_valid;
  logic         ovf_pos;
  logic         ovf_neg;
  logic         sticky_ovf;

  always #5 clk = ~clk;

`ifdef ADDITION_SAT_COUNT_EN
  logic [15:0]  sat_count;
  logic [1:0]   sat_count2;
  logic [W-1:0] d2_s;
  logic [W-1:0] d2_sq;
  logic         d2_vld;
  logic         d2_pos;
  logic         d2_neg;
  logic         d2_sticky;
`endif

  addition #(
    .WIDTH     (W),
    .CNT_WIDTH (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .A          (A),
    .B          (B),
    .S          (S),
    .in_valid   (in_valid),
    .S_q        (S_q),
    .out_valid  (out_valid),
    .ovf_pos    (ovf_pos),
    .ovf_neg    (ovf_neg),
    .sticky_ovf (sticky_ovf),
    .clr_sticky (clr_sticky)
`ifdef ADDITION_SAT_COUNT_EN
    ,
    .sat_count  (sat_count)
`endif
  );

`ifdef ADDITION_SAT_COUNT_EN
  addition #(
    .WIDTH     (W),
    .CNT_WIDTH (2)
  ) dut2 (
    .clk        (clk),
    .rst        (rst),
    .A          (A),
    .B          (B),
    .S          (d2_s),
    .in_valid   (in_valid),
    .S_q        (d2_sq),
    .out_valid  (d2_vld),
    .ovf_pos    (d2_pos),
    .ovf_neg    (d2_neg),
    .sticky_ovf (d2_sticky),
    .clr_sticky (clr_sticky),
    .sat_count  (sat_count2)
  );
`endif

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: what the registered outputs must show after each edge.
  logic [W-1:0] m_sq;
  bit           m_vld, m_pos, m_neg, m_sticky;
  int           m_cnt;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] s;
    bit           pos;
    bit           neg;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] s, output bit p, output bit n);
    int sum, hi, lo;
    sum = int'($signed(a)) + int'($signed(b));
    hi  = (2 ** (W - 1)) - 1;
    lo  = -(2 ** (W - 1));
    p   = (sum > hi);
    n   = (sum < lo);
    if (p)      s = hi[W-1:0];
    else if (n) s = lo[W-1:0];
    else        s = sum[W-1:0];
  endfunction

  task automatic cycle(input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit iv, input bit clr, input bit r);
    logic [W-1:0] es;
    bit ep, en;
    A = a; B = b; in_valid = iv; clr_sticky = clr; rst = r;
    #1;
    ref_add(a, b, es, ep, en);
    chk("S_comb", S, es);
    @(posedge clk);
    if (r) begin
      m_sq = '0; m_vld = 0; m_pos = 0; m_neg = 0; m_sticky = 0; m_cnt = 0;
    end else begin
      m_vld = iv;
      if (iv) begin
        m_sq = es; m_pos = ep; m_neg = en;
      end
      if (iv && (ep || en)) begin
        m_sticky = 1;
        m_cnt    = clr ? 1 : m_cnt + 1;
      end else if (clr) begin
        m_sticky = 0;
        m_cnt    = 0;
      end
    end
    #1;
    chk("S_q", S_q, m_sq);
    chk("out_valid", out_valid, m_vld);
    chk("ovf_pos", ovf_pos, m_pos);
    chk("ovf_neg", ovf_neg, m_neg);
    chk("sticky_ovf", sticky_ovf, m_sticky);
    chk("ovf_exclusive", ovf_pos & ovf_neg, 0);
`ifdef ADDITION_SAT_COUNT_EN
    chk("sat_count", sat_count, (m_cnt > 65535) ? 65535 : m_cnt);
    chk("sat_count_w2", sat_count2, (m_cnt > 3) ? 3 : m_cnt);
`endif
  endtask

  function automatic logic [W-1:0] pick_operand();
    logic [W-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = 16'h7FFF;
      1:       v = 16'h8000;
      2:       v = 16'hFFFF;
      3:       v = 16'h4000 + 16'($urandom_range(0, 16'h3FFF));
      default: v = 16'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    vecs[0] = '{16'h0180, 16'h0340, 16'h04C0, 0, 0};
    vecs[1] = '{16'h0180, 16'hFCC0, 16'hFE40, 0, 0};
    vecs[2] = '{16'hFE80, 16'h0340, 16'h01C0, 0, 0};
    vecs[3] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 1, 0};
    vecs[4] = '{16'h8000, 16'hFFFF, 16'h8000, 0, 1};
    vecs[5] = '{16'h7FFE, 16'h0001, 16'h7FFF, 0, 0};
    vecs[6] = '{16'h8000, 16'h8000, 16'h8000, 0, 1};
    vecs[7] = '{16'h7FFF, 16'h8000, 16'hFFFF, 0, 0};
    vecs[8] = '{16'h0001, 16'hFFFF, 16'h0000, 0, 0};
    vecs[9] = '{16'h8001, 16'hFFFF, 16'h8000, 0, 0};

    m_sq = '0; m_vld = 0; m_pos = 0; m_neg = 0; m_sticky = 0; m_cnt = 0;
    A = '0; B = '0; in_valid = 0; clr_sticky = 0; rst = 1;
    #2;

    cycle(16'h1234, 16'h1111, 1, 0, 1);
    cycle(16'h0000, 16'h0000, 0, 0, 1);
    chk("rst_S_q", S_q, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sticky", sticky_ovf, 0);

    // Back-to-back table vectors: continuous out_valid, registered values one edge later.
    foreach (vecs[i]) begin
      cycle(vecs[i].a, vecs[i].b, 1, 0, 0);
      chk("tbl_S_q", S_q, vecs[i].s);
      chk("tbl_ovf_pos", ovf_pos, vecs[i].pos);
      chk("tbl_ovf_neg", ovf_neg, vecs[i].neg);
      chk("tbl_out_valid", out_valid, 1);
    end
    chk("tbl_sticky", sticky_ovf, 1);

    // Idle: out_valid drops, S_q and flags hold.
    cycle(16'h0001, 16'h0001, 0, 0, 0);
    chk("idle_out_valid", out_valid, 0);
    chk("idle_S_q_hold", S_q, 16'h8000);

    // Saturating sample then clear.
    cycle(16'h7FFF, 16'h7FFF, 1, 0, 0);
    cycle(16'h0000, 16'h0000, 0, 1, 0);
    chk("clr_sticky", sticky_ovf, 0);
    chk("clr_ovf_pos_hold", ovf_pos, 1);

    // Single pulse gives exactly one out_valid cycle.
    cycle(16'h0180, 16'h0340, 1, 0, 0);
    chk("pulse_S_q", S_q, 16'h04C0);
    chk("pulse_vld", out_valid, 1);
    cycle(16'h0180, 16'h0340, 0, 0, 0);
    chk("pulse_vld_drop", out_valid, 0);

    // Clear coincident with saturation: set wins.
    cycle(16'h8000, 16'hFFFF, 1, 1, 0);
    chk("clr_vs_set_sticky", sticky_ovf, 1);
    chk("clr_vs_set_neg", ovf_neg, 1);

    // Reset while a sample is offered discards it.
    cycle(16'h7FFF, 16'h7FFF, 1, 0, 1);
    chk("rstmid_S_q", S_q, 0);
    chk("rstmid_vld", out_valid, 0);
    chk("rstmid_pos", ovf_pos, 0);
    chk("rstmid_sticky", sticky_ovf, 0);

    // Five saturating samples: narrow counter holds at its maximum.
    for (int i = 0; i < 5; i++) cycle(16'h7FFF, 16'h0100, 1, 0, 0);
`ifdef ADDITION_SAT_COUNT_EN
    chk("cnt_limit_w2", sat_count2, 3);
    chk("cnt_five", sat_count, 5);
`endif
    chk("five_sticky", sticky_ovf, 1);

    for (int i = 0; i < 400; i++) begin
      cycle(pick_operand(), pick_operand(),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 63) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/addition.md
Name: addition

Overview:
- Signed two's-complement saturating adder for the fixed-point datapath of the digital filter.
- Provides a combinational sum `S` for zero-latency use inside the filter.
- Also provides a one-cycle registered copy with a valid strobe, per-sample overflow flags and a sticky overflow status.
- The binary-point position is irrelevant: both operands share the same Q-format and the result keeps it.

Parameters:
- WIDTH, 16, operand and result width in bits (two's complement, ≥2).
- CNT_WIDTH, 16, width of the saturation event counter (optional feature only).

Ports:
- clk, input, 1, system clock, rising edge.
- rst, input, 1, synchronous active-high reset.
- A, input, WIDTH, signed operand A.
- B, input, WIDTH, signed operand B.
- S, output, WIDTH, combinational saturated sum of A and B.
- in_valid, input, 1, A/B hold a sample to be registered this cycle.
- S_q, output, WIDTH, registered saturated sum.
- out_valid, output, 1, S_q holds a new result this cycle.
- ovf_pos, output, 1, registered: last captured sample clipped to the maximum.
- ovf_neg, output, 1, registered: last captured sample clipped to the minimum.
- sticky_ovf, output, 1, set on any clipped captured sample; held until cleared.
- clr_sticky, input, 1, clears sticky_ovf (and sat_count when present).
- sat_count, output, CNT_WIDTH, saturation event counter; present only with the optional feature.

Behaviour:
- Full sum is computed at WIDTH+1 bits with sign extension of both operands.
- Positive overflow: both operands non-negative and the full sum exceeds 2^(WIDTH-1)-1 → S = 0111…1 (0x7FFF for WIDTH=16).
- Negative overflow: both operands negative and the full sum is below -2^(WIDTH-1) → S = 1000…0 (0x8000).
- Otherwise S = low WIDTH bits of the sum, exact, with no rounding.
- Mixed-sign operands never saturate.
- S is purely combinational: no clock dependency and zero latency, valid within the same delta/settling time.
- Registered path, on each rising clk:
  - If rst: S_q=0, out_valid=0, ovf_pos=0, ovf_neg=0, sticky_ovf=0, sat_count=0.
  - Else if in_valid: S_q←S, out_valid←1, ovf_pos/ovf_neg← that sample's flags.
  - Else: out_valid←0; S_q and the flags hold.
- Latency: in_valid high at edge N → out_valid high after edge N, for exactly one cycle per accepted sample. Back-to-back in_valid gives a continuous out_valid.
- sticky_ovf:
  - Set when an accepted sample saturates.
  - clr_sticky clears it.
  - Simultaneous clr_sticky and saturating sample → set wins (the event is not lost).
- ovf_pos and ovf_neg are never both 1.
- Reset mid-stream discards the in-flight sample: out_valid=0 on the following cycle.
- rst has priority over in_valid and clr_sticky.

Optional Feature:
- Macro ADDITION_SAT_COUNT_EN.
- Defined:
  - sat_count port exists; it increments by 1 for each accepted saturating sample.
  - It saturates at all-ones and does not wrap.
  - clr_sticky or rst clears it to 0.
  - Simultaneous clear and event → count = 1.
- Undefined: sat_count port and counter logic are absent; all other behaviour is identical.

Decomposition:
- Shared package addition_pkg holds:
  - Functions sat_max(WIDTH) and sat_min(WIDTH).
  - A typedef for the overflow status {NONE, POS, NEG}.
- One natural sub-module: sat_add_comb, the purely combinational saturating adder producing S and overflow status. The top instantiates it and adds the registers, sticky flag and counter.

Test Plan:
- A=0x0180, B=0x0340 → S=0x04C0, no flags. With in_valid pulsed, S_q=0x04C0 and out_valid high one cycle later.
- A=0x0180, B=0xFCC0 → S=0xFE40. A=0xFE80, B=0x0340 → S=0x01C0. No flags in either case.
- A=0x7FFF, B=0x7FFF, in_valid → S=0x7FFF, ovf_pos=1 registered, sticky_ovf=1. With the macro defined, sat_count=1.
- A=0x8000, B=0xFFFF, in_valid → S=0x8000, ovf_neg=1. Boundary A=0x7FFE, B=0x0001 → 0x7FFF with no flag.
- Sticky and count behaviour:
  - Saturating sample then clr_sticky → sticky_ovf=0, sat_count=0.
  - clr_sticky asserted together with a saturating sample → sticky_ovf=1, sat_count=1.
- Reset and counter limit:
  - rst asserted while in_valid=1 → next cycle S_q=0, out_valid=0, all flags 0.
  - CNT_WIDTH=2 with 5 saturating samples → sat_count holds at 3.
